// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline: ALU op codes, the ID/EX
// register layout and small helpers used by the ID/EX stage.
package pipe_pkg;

  // Datapath widths the ID/EX register layout is built for. The stage
  // parameters default to these values and are expected to match them.
  localparam int XLEN    = 32;
  localparam int XADDR_W = 5;

  // 4-bit ALU control codes understood by the execute-stage ALU.
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1011,
    ALU_SLTU = 4'b1110
  } alu_op_e;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [XADDR_W-1:0] rs1;
    logic [XADDR_W-1:0] rs2;
    logic [XADDR_W-1:0] rd;
    logic [3:0]         alu_control;
    logic               alu_src;
    logic               alu_src_pc;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
  } id_ex_t;

  // A bubble is an all-zero entry that still presents ADD to the ALU, so
  // an empty EX stage computes 0 + 0 instead of an arbitrary operation.
  function automatic id_ex_t bubble_entry();
    id_ex_t e;
    e             = '0;
    e.alu_control = ALU_ADD;
    return e;
  endfunction

  // Shift ops take their amount from the low five bits of operand 2 only.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand bypass for one source register: picks the youngest in-flight
// result (EX/MEM first, then MEM/WB) that targets the requested index,
// otherwise passes the value already held in the ID/EX register.
module forward_unit #(
  parameter int REG_WIDTH  = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_idx,
  input  logic [REG_WIDTH-1:0]  reg_value,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_WIDTH-1:0]  mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [REG_WIDTH-1:0]  wb_result,
  output logic [REG_WIDTH-1:0]  fwd_value
);

  // Bypass select: x0 is hardwired zero, so a write to it is never forwarded.
  always_comb begin
    fwd_value = reg_value;
    if (src_idx != '0) begin
      if (mem_reg_write && (mem_rd == src_idx)) begin
        fwd_value = mem_result;
      end else if (wb_reg_write && (wb_rd == src_idx)) begin
        fwd_value = wb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard
// detection and ALU operand selection for the RV32I execute stage.
//
// Hold semantics: stall and hazard_stall are level signals sampled on the
// rising edge. stall (from outside) freezes this entry; hazard_stall (from
// here) tells IF/ID to hold its instruction while this stage inserts a
// bubble, and the held instruction is accepted on the first edge where
// hazard_stall is low. flush overrides both and squashes the entry.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int REG_WIDTH  = XLEN,
  parameter int REG_ADDR_W = XADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_WIDTH-1:0]  id_pc,
  input  logic [REG_WIDTH-1:0]  id_rs1_data,
  input  logic [REG_WIDTH-1:0]  id_rs2_data,
  input  logic [REG_WIDTH-1:0]  id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [3:0]            id_alu_control,
  input  logic                  id_alu_src,
  input  logic                  id_alu_src_pc,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_WIDTH-1:0]  mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [REG_WIDTH-1:0]  wb_result,
  output logic                  hazard_stall,
  output logic [REG_WIDTH-1:0]  alu_in1,
  output logic [REG_WIDTH-1:0]  alu_in2,
  output logic [3:0]            alu_control,
  output logic                  ex_valid,
  output logic [REG_WIDTH-1:0]  ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_WIDTH-1:0]  ex_store_data,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg
);

  id_ex_t               ex_q;
  id_ex_t               ex_d;
  id_ex_t               id_entry;
  logic [REG_WIDTH-1:0] fwd_rs1;
  logic [REG_WIDTH-1:0] fwd_rs2;
  logic [REG_WIDTH-1:0] op2;
  logic                 rs1_conflict;
  logic                 rs2_conflict;

  // Bypass for the registered rs1 index.
  forward_unit #(
    .REG_WIDTH (REG_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs1 (
    .src_idx      (ex_q.rs1),
    .reg_value    (ex_q.rs1_data),
    .mem_reg_write(mem_reg_write),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .fwd_value    (fwd_rs1)
  );

  // Bypass for the registered rs2 index.
  forward_unit #(
    .REG_WIDTH (REG_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs2 (
    .src_idx      (ex_q.rs2),
    .reg_value    (ex_q.rs2_data),
    .mem_reg_write(mem_reg_write),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .fwd_value    (fwd_rs2)
  );

  // Load-use detection: a load in EX cannot forward in time to a consumer
  // in ID. rs2 only matters when it is actually read (register operand or
  // store data).
  always_comb begin
    rs1_conflict = (ex_q.rd == id_rs1);
    rs2_conflict = (ex_q.rd == id_rs2) && (!id_alu_src || id_mem_write);
    hazard_stall = id_valid && !flush && ex_q.valid && ex_q.mem_read &&
                   (ex_q.rd != '0) && (rs1_conflict || rs2_conflict);
  end

  // Entry built from the ID stage; control bits of a non-instruction are
  // cleared so they can never reach EX/MEM.
  always_comb begin
    id_entry             = '0;
    id_entry.valid       = id_valid;
    id_entry.pc          = id_pc;
    id_entry.rs1_data    = id_rs1_data;
    id_entry.rs2_data    = id_rs2_data;
    id_entry.imm         = id_imm;
    id_entry.rs1         = id_rs1;
    id_entry.rs2         = id_rs2;
    id_entry.rd          = id_rd;
    id_entry.alu_control = id_alu_control;
    id_entry.alu_src     = id_alu_src;
    id_entry.alu_src_pc  = id_alu_src_pc;
    id_entry.reg_write   = id_valid && id_reg_write;
    id_entry.mem_read    = id_valid && id_mem_read;
    id_entry.mem_write   = id_valid && id_mem_write;
    id_entry.mem_to_reg  = id_valid && id_mem_to_reg;
  end

  // Next-entry select: flush > stall > load-use bubble > normal load. A
  // held entry refreshes its operand data with the forwarded values so a
  // result retiring from WB during the hold is kept.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = bubble_entry();
    end else if (stall) begin
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else if (hazard_stall) begin
      ex_d = bubble_entry();
    end else begin
      ex_d = id_entry;
    end
  end

  // ID/EX register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= bubble_entry();
    end else begin
      ex_q <= ex_d;
    end
  end

  // Operand muxes; shift amounts are trimmed to five bits because the ALU
  // shifts by its whole second operand.
  always_comb begin
    alu_in1 = ex_q.alu_src_pc ? ex_q.pc : fwd_rs1;
    op2     = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    if (is_shift(ex_q.alu_control)) begin
      alu_in2 = {{(REG_WIDTH-5){1'b0}}, op2[4:0]};
    end else begin
      alu_in2 = op2;
    end
  end

  // Registered fields toward EX/MEM; control bits are qualified by valid.
  always_comb begin
    alu_control   = ex_q.alu_control;
    ex_valid      = ex_q.valid;
    ex_pc         = ex_q.pc;
    ex_rd         = ex_q.rd;
    ex_store_data = fwd_rs2;
    ex_reg_write  = ex_q.valid && ex_q.reg_write;
    ex_mem_read   = ex_q.valid && ex_q.mem_read;
    ex_mem_write  = ex_q.valid && ex_q.mem_write;
    ex_mem_to_reg = ex_q.valid && ex_q.mem_to_reg;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a table of directed vectors, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int OBS_W = 143;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [W-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]    id_alu_control;
  logic          id_alu_src, id_alu_src_pc;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          stall, flush;
  logic          mem_reg_write;
  logic [AW-1:0] mem_rd;
  logic [W-1:0]  mem_result;
  logic          wb_reg_write;
  logic [AW-1:0] wb_rd;
  logic [W-1:0]  wb_result;
  logic          hazard_stall;
  logic [W-1:0]  alu_in1, alu_in2;
  logic [3:0]    alu_control;
  logic          ex_valid;
  logic [W-1:0]  ex_pc;
  logic [AW-1:0] ex_rd;
  logic [W-1:0]  ex_store_data;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  always #5 clk = ~clk;

  id_ex_stage #(.REG_WIDTH(W), .REG_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_alu_src_pc(id_alu_src_pc), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .stall(stall), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .hazard_stall(hazard_stall), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_control(alu_control), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; stall = 1'b0;
    id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_control = ALU_ADD;
    id_alu_src = 1'b0; id_alu_src_pc = 1'b0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic drive_id(input int rs1, input int rs2, input int rd, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] imm, input logic [3:0] op,
                          input logic src, input logic mr, input logic mw);
    id_valid = 1'b1; id_pc = 32'h1000;
    id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_rd = AW'(rd);
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_control = op;
    id_alu_src = src; id_alu_src_pc = 1'b0;
    id_reg_write = ~mw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mr;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, fl, st, iv;
    logic [AW-1:0] rs1, rs2, rd;
    logic [W-1:0] d1, d2, imm;
    logic [3:0] op;
    logic src, mr, mw;
    logic mrw; logic [AW-1:0] mrd; logic [W-1:0] mres;
    logic wrw; logic [AW-1:0] wrd; logic [W-1:0] wres;
    logic e_valid, e_haz;
    logic [W-1:0] e_in1, e_in2;
    logic [3:0] e_op;
  } vec_t;

  function automatic vec_t mk(input int r, f, s, iv, rs1, rs2, rd, d1, d2, imm, op, src, mr, mw,
                              mrw, mrd, mres, wrw, wrd, wres, ev, eh, ein1, ein2, eop);
    vec_t v;
    v.rst = 1'(r); v.fl = 1'(f); v.st = 1'(s); v.iv = 1'(iv);
    v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.rd = AW'(rd);
    v.d1 = W'(d1); v.d2 = W'(d2); v.imm = W'(imm); v.op = 4'(op);
    v.src = 1'(src); v.mr = 1'(mr); v.mw = 1'(mw);
    v.mrw = 1'(mrw); v.mrd = AW'(mrd); v.mres = W'(mres);
    v.wrw = 1'(wrw); v.wrd = AW'(wrd); v.wres = W'(wres);
    v.e_valid = 1'(ev); v.e_haz = 1'(eh); v.e_in1 = W'(ein1); v.e_in2 = W'(ein2);
    v.e_op = 4'(eop);
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    idle_inputs();
    reset = v.rst; flush = v.fl; stall = v.st;
    drive_id(int'(v.rs1), int'(v.rs2), int'(v.rd), v.d1, v.d2, v.imm, v.op, v.src, v.mr, v.mw);
    id_valid = v.iv;
    mem_reg_write = v.mrw; mem_rd = v.mrd; mem_result = v.mres;
    wb_reg_write = v.wrw; wb_rd = v.wrd; wb_result = v.wres;
  endtask

  // ---------------- reference model ----------------
  // The EX slot as a record: which instruction sits there and what it reads.
  logic          m_valid;
  logic [W-1:0]  m_pc, m_imm;
  logic [AW-1:0] m_src [2];
  logic [W-1:0]  m_val [2];
  logic [AW-1:0] m_rd;
  logic [3:0]    m_op;
  logic          m_use_imm, m_use_pc;
  logic          m_rw, m_mr, m_mw, m_m2r;

  task automatic model_bubble();
    m_valid = 1'b0; m_pc = '0; m_imm = '0; m_src[0] = '0; m_src[1] = '0;
    m_val[0] = '0; m_val[1] = '0; m_rd = '0; m_op = ALU_ADD;
    m_use_imm = 1'b0; m_use_pc = 1'b0;
    m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_m2r = 1'b0;
  endtask

  // Newest architectural value of register idx as seen right now.
  function automatic logic [W-1:0] reg_value(input logic [AW-1:0] idx, input logic [W-1:0] held);
    if (idx == 0) return held;
    if (mem_reg_write && mem_rd == idx) return mem_result;
    if (wb_reg_write && wb_rd == idx) return wb_result;
    return held;
  endfunction

  function automatic logic model_hazard();
    logic reads_rs2;
    reads_rs2 = (id_alu_src == 1'b0) || id_mem_write;
    return id_valid && !flush && m_valid && m_mr && m_rd != 0 &&
           (m_rd == id_rs1 || (reads_rs2 && m_rd == id_rs2));
  endfunction

  function automatic logic [OBS_W-1:0] model_outputs();
    logic [W-1:0] a, b, sd;
    a  = m_use_pc ? m_pc : reg_value(m_src[0], m_val[0]);
    sd = reg_value(m_src[1], m_val[1]);
    b  = m_use_imm ? m_imm : sd;
    if (m_op == ALU_SLL || m_op == ALU_SRL || m_op == ALU_SRA) b = b % 32;
    return {model_hazard(), a, b, m_op, m_valid, m_pc, m_rd, sd,
            m_valid & m_rw, m_valid & m_mr, m_valid & m_mw, m_valid & m_m2r};
  endfunction

  // Advance the model across one clock edge using the pre-edge inputs.
  task automatic model_edge();
    logic [W-1:0] n0, n1;
    if (reset || flush || (!stall && model_hazard())) begin
      model_bubble();
    end else if (stall) begin
      n0 = reg_value(m_src[0], m_val[0]);
      n1 = reg_value(m_src[1], m_val[1]);
      m_val[0] = n0; m_val[1] = n1;
    end else begin
      m_valid = id_valid; m_pc = id_pc; m_imm = id_imm;
      m_src[0] = id_rs1; m_src[1] = id_rs2;
      m_val[0] = id_rs1_data; m_val[1] = id_rs2_data;
      m_rd = id_rd; m_op = id_alu_control;
      m_use_imm = id_alu_src; m_use_pc = id_alu_src_pc;
      m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write; m_m2r = id_mem_to_reg;
    end
  endtask

  logic [3:0] ops [9] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB,
                          ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLTU};

  task automatic drive_random(input bit force_reset);
    reset = force_reset || ($urandom_range(0, 63) == 0);
    flush = ($urandom_range(0, 15) == 0);
    stall = ($urandom_range(0, 7) == 0);
    id_valid = ($urandom_range(0, 7) != 0);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = AW'($urandom_range(0, 7)); id_rs2 = AW'($urandom_range(0, 7));
    id_rd = AW'($urandom_range(0, 7));
    id_alu_control = ops[$urandom_range(0, 8)];
    id_alu_src = 1'($urandom_range(0, 1)); id_alu_src_pc = 1'($urandom_range(0, 1));
    id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = 1'($urandom_range(0, 1));
    id_mem_write = 1'($urandom_range(0, 1)); id_mem_to_reg = 1'($urandom_range(0, 1));
    mem_reg_write = 1'($urandom_range(0, 1)); mem_rd = AW'($urandom_range(0, 7));
    mem_result = $urandom;
    wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = AW'($urandom_range(0, 7));
    wb_result = $urandom;
  endtask

  // ---------------- scoreboard ----------------
  logic [OBS_W-1:0] exp_q [$];

  task automatic score_cycle();
    logic [OBS_W-1:0] act, exp;
    exp_q.push_back(model_outputs());
    act = {hazard_stall, alu_in1, alu_in2, alu_control, ex_valid, ex_pc, ex_rd,
           ex_store_data, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
    exp = exp_q.pop_front();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL rand t=%0t: got %h expected %h", $time, act, exp);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl [17];

  initial begin
    tbl[0]  = mk(1,0,0, 1,1,2,3, 5,7,0, ALU_ADD,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,ALU_ADD);
    tbl[1]  = mk(1,0,0, 1,1,2,3, 5,7,0, ALU_ADD,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,ALU_ADD);
    tbl[2]  = mk(0,0,0, 1,1,2,3, 5,7,0, ALU_ADD,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,ALU_ADD);
    tbl[3]  = mk(0,0,0, 0,0,0,0, 0,0,0, ALU_ADD,0,0,0, 1,1,100, 1,1,50, 1,0,100,7,ALU_ADD);
    tbl[4]  = mk(0,0,0, 1,0,2,5, 'h1234,9,0, ALU_ADD,0,0,0, 1,0,'hDEAD, 0,0,0, 0,0,0,0,ALU_ADD);
    tbl[5]  = mk(0,0,0, 1,6,0,4, 'h200,0,'h10, ALU_ADD,1,1,0, 1,0,'hDEAD, 0,0,0, 1,0,'h1234,9,ALU_ADD);
    tbl[6]  = mk(0,0,0, 1,4,0,7, 'h11,0,0, ALU_ADD,0,0,0, 0,0,0, 0,0,0, 1,1,'h200,'h10,ALU_ADD);
    tbl[7]  = mk(0,0,0, 1,4,0,7, 'h11,0,0, ALU_ADD,0,0,0, 1,4,'h77, 0,0,0, 0,0,0,0,ALU_ADD);
    tbl[8]  = mk(0,0,0, 1,9,10,8, 'hF0000000,'h123,0, ALU_SRA,0,0,0, 0,0,0, 1,4,'h77, 1,0,'h77,0,ALU_ADD);
    tbl[9]  = mk(0,0,0, 0,0,0,0, 0,0,0, ALU_ADD,0,0,0, 0,0,0, 0,0,0, 1,0,'hF0000000,3,ALU_SRA);
    tbl[10] = mk(0,0,0, 1,1,0,2, 'h80,0,'h405, ALU_SRA,1,0,0, 0,0,0, 0,0,0, 0,0,0,0,ALU_ADD);
    tbl[11] = mk(0,0,0, 0,0,0,0, 0,0,0, ALU_ADD,0,0,0, 0,0,0, 0,0,0, 1,0,'h80,5,ALU_SRA);
    tbl[12] = mk(0,0,0, 1,0,0,5, 'h40,0,8, ALU_ADD,1,1,0, 0,0,0, 0,0,0, 0,0,0,0,ALU_ADD);
    tbl[13] = mk(0,0,0, 1,1,5,6, 3,'hAB,1, ALU_ADD,1,0,0, 0,0,0, 0,0,0, 1,0,'h40,8,ALU_ADD);
    tbl[14] = mk(0,0,0, 1,0,0,5, 'h40,0,8, ALU_ADD,1,1,0, 0,0,0, 0,0,0, 1,0,3,1,ALU_ADD);
    tbl[15] = mk(0,0,0, 1,0,5,0, 'h40,'hCC,4, ALU_ADD,1,0,1, 0,0,0, 0,0,0, 1,1,'h40,8,ALU_ADD);
    tbl[16] = mk(0,0,0, 1,0,5,0, 'h40,'hCC,4, ALU_ADD,1,0,1, 0,0,0, 0,0,0, 0,0,0,0,ALU_ADD);

    idle_inputs();
    #1;

    // Directed table: outputs checked mid-cycle, then the edge is taken.
    for (int i = 0; i < 17; i++) begin
      apply_vec(tbl[i]);
      @(negedge clk);
      checkb($sformatf("tbl%0d ex_valid", i), ex_valid, tbl[i].e_valid);
      checkb($sformatf("tbl%0d hazard_stall", i), hazard_stall, tbl[i].e_haz);
      check($sformatf("tbl%0d alu_in1", i), alu_in1, tbl[i].e_in1);
      check($sformatf("tbl%0d alu_in2", i), alu_in2, tbl[i].e_in2);
      check($sformatf("tbl%0d alu_control", i), 32'(alu_control), 32'(tbl[i].e_op));
      if (i < 2) begin
        checkb($sformatf("tbl%0d reset ex_reg_write", i), ex_reg_write, 1'b0);
        checkb($sformatf("tbl%0d reset ex_mem_read", i), ex_mem_read, 1'b0);
      end
      @(posedge clk);
      #1;
    end

    // Stall keeps the entry and absorbs a WB retirement into rs2.
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_id(1, 2, 3, 32'h1, 32'h2, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b0);
    tick();
    idle_inputs();
    stall = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd2; wb_result = 32'h55;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d alu_in2", c), alu_in2, 32'h55);
      checkb($sformatf("stall%0d ex_valid", c), ex_valid, 1'b1);
      tick();
    end
    wb_reg_write = 1'b0; wb_result = 32'h0;
    @(negedge clk);
    check("stall wb-cleared alu_in2", alu_in2, 32'h55);
    check("stall wb-cleared store_data", ex_store_data, 32'h55);
    check("stall held alu_in1", alu_in1, 32'h1);
    tick();

    // Flush together with stall loads a bubble.
    flush = 1'b1; stall = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    checkb("flush+stall ex_valid", ex_valid, 1'b0);
    checkb("flush+stall ex_reg_write", ex_reg_write, 1'b0);
    check("flush+stall alu_control", 32'(alu_control), 32'(ALU_ADD));
    check("flush+stall alu_in2", alu_in2, 32'h0);

    // Flush suppresses a load-use hazard.
    drive_id(0, 0, 4, 32'h0, 32'h0, 32'h8, ALU_ADD, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(4, 0, 6, 32'h0, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checkb("flush hides hazard", hazard_stall, 1'b0);
    tick();

    // Stall beats hazard: the load stays in EX.
    idle_inputs();
    drive_id(0, 0, 4, 32'h0, 32'h0, 32'h8, ALU_ADD, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(4, 0, 6, 32'h0, 32'h0, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    @(negedge clk);
    checkb("hazard under stall", hazard_stall, 1'b1);
    tick();
    @(negedge clk);
    checkb("stall holds load valid", ex_valid, 1'b1);
    checkb("stall holds load mem_read", ex_mem_read, 1'b1);
    check("stall holds load rd", 32'(ex_rd), 32'd4);
    tick();

    // Randomized traffic against the model, starting from a reset edge.
    model_bubble();
    for (int n = 0; n < 3000; n++) begin
      drive_random(n == 0);
      @(negedge clk);
      if (n > 0) score_cycle();
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
